ideab_run_ctrl: RTL and testbench

Run controller for the 4-bit skip-decrement state sequence (next = state−1, except 0101 → 1110). The controller:
- loads a seed value on request;
- steps the sequence one state per enabled cycle until it reaches a requested target;
- reports the step count, then signals completion.

It sits between the top-level test/control logic and the sequence register. It replaces free-running operation with a start/done handshake.

---
 rtl/ideab_pkg.sv | 16 +
 rtl/ideab_next_state.sv | 18 +
 rtl/ideab_run_ctrl.sv | 110 +++++++++++
 tb/tb_ideab_run_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ideab_pkg.sv
// Shared definitions for the skip-decrement sequence and its run controller.
// Consumers import ideab_pkg::* for the FSM encoding and sequence constants.
package ideab_pkg;

  localparam int SEQ_W = 4;
  localparam logic [SEQ_W-1:0] SKIP_FROM = 4'b0101;
  localparam logic [SEQ_W-1:0] SKIP_TO   = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } run_state_t;

endpackage

// File: rtl/ideab_next_state.sv
// Combinational step function of the skip-decrement sequence:
// next = state - 1 (wrapping), except SKIP_FROM jumps to SKIP_TO.
module ideab_next_state
  import ideab_pkg::*;
(
  input  logic [SEQ_W-1:0] cur,
  output logic [SEQ_W-1:0] nxt
);

  always_comb begin
    if (cur == SKIP_FROM) begin
      nxt = SKIP_TO;
    end else begin
      nxt = cur - 4'd1;
    end
  end

endmodule

// File: rtl/ideab_run_ctrl.sv
// Start/done run controller stepping the skip-decrement sequence from a seed to a target.
// Optional RUN_TIMEOUT_EN adds a FAIL state with a TIMEOUT pulse after MAX_STEPS steps.
module ideab_run_ctrl
  import ideab_pkg::*;
#(
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              PAUSE,
  input  logic [SEQ_W-1:0]  SEED,
  input  logic [SEQ_W-1:0]  TARGET,
  output logic [SEQ_W-1:0]  STATE,
  output logic              CE,
  output logic              BUSY,
  output logic              DONE,
  output logic              TIMEOUT,
  output logic [STEP_W-1:0] STEPS
);

`ifdef RUN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_SAT   = '1;
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  run_state_t        fsm_reg, fsm_next;
  logic [SEQ_W-1:0]  seq_reg;
  logic [SEQ_W-1:0]  target_reg;
  logic [STEP_W-1:0] steps_reg;
  logic [SEQ_W-1:0]  seq_step;
  logic              load;
  logic              step_en;
  logic              match;
  logic              timeout_hit;

  ideab_next_state u_next (
    .cur (seq_reg),
    .nxt (seq_step)
  );

  assign match       = (seq_reg == target_reg);
  assign timeout_hit = TIMEOUT_EN && (steps_reg == STEP_LIMIT);

  // RUN priority: abort, match, timeout, pause, step.
  always_comb begin
    fsm_next = fsm_reg;
    load     = 1'b0;
    step_en  = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        if (START) begin
          fsm_next = ST_RUN;
          load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          fsm_next = ST_IDLE;
        end else if (match) begin
          fsm_next = ST_DONE;
`ifdef RUN_TIMEOUT_EN
        end else if (timeout_hit) begin
          fsm_next = ST_FAIL;
`endif
        end else if (!PAUSE) begin
          step_en = 1'b1;
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_reg    <= ST_IDLE;
      seq_reg    <= '0;
      target_reg <= '0;
      steps_reg  <= '0;
    end else begin
      fsm_reg <= fsm_next;
      if (load) begin
        seq_reg    <= SEED;
        target_reg <= TARGET;
        steps_reg  <= '0;
      end else if (step_en) begin
        seq_reg <= seq_step;
        // Saturation only matters when no timeout bounds the run.
        if (steps_reg != STEP_SAT) begin
          steps_reg <= steps_reg + STEP_ONE;
        end
      end
    end
  end

  assign STATE   = seq_reg;
  assign STEPS   = steps_reg;
  assign CE      = step_en;
  assign BUSY    = (fsm_reg == ST_RUN);
  assign DONE    = (fsm_reg == ST_DONE);
  assign TIMEOUT = (fsm_reg == ST_FAIL);

endmodule

// File: tb/tb_ideab_run_ctrl.sv
// Self-checking bench for ideab_run_ctrl: table of runs plus abort, long-run and reset sequences.
// Build with +define+RUN_TIMEOUT_EN to exercise the timeout variant.
module tb_ideab_run_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       PAUSE = 1'b0;
  logic [3:0] SEED = 4'd0;
  logic [3:0] TARGET = 4'd0;
  logic [3:0] STATE;
  logic       CE, BUSY, DONE, TIMEOUT;
  logic [7:0] STEPS;

  int checks = 0;
  int errors = 0;

  ideab_run_ctrl #(.STEP_W(8), .MAX_STEPS(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .PAUSE(PAUSE),
    .SEED(SEED), .TARGET(TARGET), .STATE(STATE), .CE(CE), .BUSY(BUSY),
    .DONE(DONE), .TIMEOUT(TIMEOUT), .STEPS(STEPS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] seed;
    logic [3:0] target;
    logic [3:0] exp_state;
    int         exp_steps;
    int         pause_from;
    int         pause_len;
    bit         glitch;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [3:0] s, input logic [3:0] t);
    START = 1'b1; SEED = s; TARGET = t;
    tick();
    START = 1'b0;
    chk("start_busy", 32'(BUSY), 32'd1);
    chk("start_state", 32'(STATE), 32'(s));
    chk("start_steps", 32'(STEPS), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ce_cnt;
    int done_at;
    bit timeout_seen;
    ce_cnt = 0; done_at = -1; timeout_seen = 0;
    start_run(v.seed, v.target);
    for (int c = 1; c <= 300; c++) begin
      PAUSE = (c > v.pause_from) && (c <= v.pause_from + v.pause_len);
      if (v.glitch && c == 2) begin
        START = 1'b1; SEED = 4'b0000; TARGET = 4'b1111;
      end else begin
        START = 1'b0;
      end
      #1;
      if (CE) ce_cnt++;
      @(posedge CLK);
      #1;
      if (TIMEOUT) timeout_seen = 1;
      if (DONE) begin
        done_at = c;
        break;
      end
    end
    PAUSE = 1'b0; START = 1'b0;
    chk($sformatf("v%0d_done_edge", idx), 32'(done_at), 32'(v.exp_steps + 1 + v.pause_len));
    chk($sformatf("v%0d_steps", idx), 32'(STEPS), 32'(v.exp_steps));
    chk($sformatf("v%0d_state", idx), 32'(STATE), 32'(v.exp_state));
    chk($sformatf("v%0d_busy_low", idx), 32'(BUSY), 32'd0);
    chk($sformatf("v%0d_ce_count", idx), 32'(ce_cnt), 32'(v.exp_steps));
    chk($sformatf("v%0d_no_timeout", idx), 32'(timeout_seen), 32'd0);
    tick();
    chk($sformatf("v%0d_done_pulse", idx), 32'(DONE), 32'd0);
    chk($sformatf("v%0d_hold_state", idx), 32'(STATE), 32'(v.exp_state));
    tick();
    $display("run %0d seed=%b target=%b done_edge=%0d steps=%0d state=%b ce=%0d",
             idx, v.seed, v.target, done_at, STEPS, STATE, ce_cnt);
  endtask

  initial begin
    bit done_seen;
    bit to_seen;
    int to_at;

    vecs[0] = '{4'b1111, 4'b0101, 4'b0101, 10, 0, 0, 1'b0};
    vecs[1] = '{4'b0101, 4'b1101, 4'b1101,  2, 0, 0, 1'b0};
    vecs[2] = '{4'b0011, 4'b1111, 4'b1111,  4, 0, 0, 1'b0};
    vecs[3] = '{4'b1000, 4'b1000, 4'b1000,  0, 0, 0, 1'b0};
    vecs[4] = '{4'b1111, 4'b0101, 4'b0101, 10, 3, 3, 1'b1};

    #3;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_steps", 32'(STEPS), 32'd0);
    chk("rst_flags", {28'd0, CE, BUSY, DONE, TIMEOUT}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("idle_busy", 32'(BUSY), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Abort after five steps from 1111: state 1010, no pulse.
    start_run(4'b1111, 4'b0010);
    repeat (5) tick();
    ABORT = 1'b1;
    #1;
    chk("abort_ce", 32'(CE), 32'd0);
    tick();
    ABORT = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_steps", 32'(STEPS), 32'd5);
    chk("abort_state", 32'(STATE), 32'b1010);
    chk("abort_pulses", {30'd0, DONE, TIMEOUT}, 32'd0);
    $display("abort steps=%0d state=%b busy=%b", STEPS, STATE, BUSY);
    tick();

    // Unreachable target.
    start_run(4'b1111, 4'b0010);
    done_seen = 0; to_seen = 0; to_at = -1;
`ifdef RUN_TIMEOUT_EN
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (DONE) done_seen = 1;
      if (TIMEOUT) begin
        to_at = c;
        break;
      end
    end
    chk("to_edge", 32'(to_at), 32'd33);
    chk("to_steps", 32'(STEPS), 32'd32);
    chk("to_state", 32'(STATE), 32'b1101);
    chk("to_no_done", 32'(done_seen), 32'd0);
    tick();
    chk("to_pulse", 32'(TIMEOUT), 32'd0);
    $display("timeout edge=%0d steps=%0d state=%b", to_at, STEPS, STATE);
    tick();
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (DONE) done_seen = 1;
      if (TIMEOUT) to_seen = 1;
    end
    chk("long_busy", 32'(BUSY), 32'd1);
    chk("long_steps", 32'(STEPS), 32'd100);
    chk("long_state", 32'(STATE), 32'b0101);
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (DONE) done_seen = 1;
      if (TIMEOUT) to_seen = 1;
    end
    chk("long_sat", 32'(STEPS), 32'd255);
    chk("long_no_pulse", {30'd0, done_seen, to_seen}, 32'd0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("long_abort_busy", 32'(BUSY), 32'd0);
    $display("long run steps=%0d busy=%b after abort", STEPS, BUSY);
    tick();
`endif

    // Asynchronous reset between edges mid-run.
    start_run(4'b1111, 4'b0101);
    repeat (4) tick();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_state", 32'(STATE), 32'd0);
    chk("arst_steps", 32'(STEPS), 32'd0);
    chk("arst_flags", {28'd0, CE, BUSY, DONE, TIMEOUT}, 32'd0);
    done_seen = 0;
    repeat (2) begin
      tick();
      if (DONE || TIMEOUT) done_seen = 1;
    end
    RST = 1'b0;
    tick();
    chk("arst_no_pulse", 32'(done_seen), 32'd0);
    $display("reset mid-run state=%b steps=%0d", STATE, STEPS);
    run_vec(5, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
